// File: rtl/cache_mem_arbiter_if.sv
// Bundle between the L1 caches, the arbiter and the physical memory port.
// slave = arbiter view; master = caches plus pmem (the arbiter's environment).
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              arb_busy;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
           arb_busy
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
           arb_busy
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares pmem between icache fills and dcache fills/write-backs; dcache first, icache starvation-bounded.
// Latency: one edge from IDLE grant to pmem strobe; requesters stall holding their request until resp.
module cache_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } pmem_req_t;

  localparam logic [3:0] W_LIMIT = 4'(STARVE_LIMIT);

  state_t    r_state, w_state_nxt;
  pmem_req_t r_req, w_req_nxt;
  logic [3:0] r_starve_cnt, w_starve_nxt;
  logic       r_dead, w_dead_nxt;
  logic       w_d_req, w_grant_d, w_grant_i;

  assign w_d_req   = bus.d_read | bus.d_write;
  assign w_grant_d = w_d_req && (!bus.i_read || (r_starve_cnt < W_LIMIT));
  assign w_grant_i = !w_grant_d && bus.i_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_starve_cnt <= '0;
      r_dead       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_dead       <= w_dead_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_starve_nxt = r_starve_cnt;
    w_dead_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_req_nxt = '0;
        if (!bus.i_read) w_starve_nxt = '0;
        // The first IDLE cycle after a serve grants nothing, so a requester still
        // holding its just-answered request is not served twice.
        if (!r_dead) begin
          if (w_grant_d) begin
            w_state_nxt     = SERVE_D;
            w_req_nxt.rd    = bus.d_read & ~bus.d_write;
            w_req_nxt.wr    = bus.d_write;
            w_req_nxt.addr  = bus.d_address;
            w_req_nxt.wdata = bus.d_wdata;
            if (bus.i_read)
              w_starve_nxt = (r_starve_cnt < W_LIMIT) ? r_starve_cnt + 4'd1 : W_LIMIT;
          end else if (w_grant_i) begin
            w_state_nxt    = SERVE_I;
            w_req_nxt.rd   = 1'b1;
            w_req_nxt.addr = bus.i_address;
            w_starve_nxt   = '0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          w_state_nxt = IDLE;
          w_req_nxt   = '0;
          w_dead_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = '0;
      end
    endcase
  end

  assign bus.pmem_read    = r_req.rd;
  assign bus.pmem_write   = r_req.wr;
  assign bus.pmem_address = r_req.addr;
  assign bus.pmem_wdata   = r_req.wdata;

  assign bus.i_resp   = (r_state == SERVE_I) & bus.pmem_resp;
  assign bus.d_resp   = (r_state == SERVE_D) & bus.pmem_resp;
  assign bus.i_rdata  = bus.pmem_rdata;
  assign bus.d_rdata  = bus.pmem_rdata;
  assign bus.arb_busy = (r_state != IDLE);
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: vector table, directed corner sequences, then random traffic vs a cycle model.
module tb_cache_mem_arbiter;
  localparam int AW    = 16;
  localparam int LW    = 128;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [145:0] pm;
  assign pm = {bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
  endtask

  typedef struct {
    logic          ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd, rd;
    int            lat;
    logic [145:0]  exp_pm;
    logic          exp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.i_read = v.ir; bus.i_address = v.ia;
    bus.d_read = v.dr; bus.d_write = v.dw; bus.d_address = v.da; bus.d_wdata = v.wd;
    @(posedge clk); #1;
    chk("vec_grant", 256'(pm), 256'(v.exp_pm));
    for (int k = 1; k < v.lat; k++) begin
      @(posedge clk); #1;
      chk("vec_hold", 256'({pm, bus.i_resp, bus.d_resp}), 256'({v.exp_pm, 2'b00}));
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = v.rd; #1;
    chk("vec_resp", 256'({bus.i_resp, bus.d_resp, (v.exp_d ? bus.d_rdata : bus.i_rdata)}),
        256'({~v.exp_d, v.exp_d, v.rd}));
    @(posedge clk); #1;
    chk("vec_after", 256'({bus.pmem_read, bus.pmem_write, bus.arb_busy, bus.i_resp, bus.d_resp}), 256'(0));
    @(negedge clk);
    idle_all();
    repeat (3) @(posedge clk);
    #1 chk("vec_quiet", 256'({bus.pmem_read, bus.pmem_write, bus.arb_busy}), 256'(0));
  endtask

  // Random-phase model state
  int           m_owner;   // 0 none, 1 icache, 2 dcache
  int           m_cool;
  int           m_cnt;
  int           m_lat;
  logic [145:0] m_exp;

  initial begin
    logic [LW-1:0] w_a5, w_beef, w_11, w_cafe, w_77;
    int   got[6];
    int   n, gap, done;
    logic was_busy, found;
    logic s_ir, s_dr, s_dw, s_resp;
    logic [AW-1:0] s_ia, s_da;
    logic [LW-1:0] s_wd;
    logic i_pend, d_pend;
    int   i_hold, d_hold;
    logic [1:0] op;

    w_a5   = {16{8'hA5}};
    w_beef = {4{32'hDEAD_BEEF}};
    w_11   = {16{8'h11}};
    w_cafe = {8{16'hCAFE}};
    w_77   = {16{8'h77}};

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, '0, w_a5, 3,
                {1'b1, 1'b0, 16'h1230, 128'h0}, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2000, w_11, ~w_a5, 2,
                {1'b1, 1'b0, 16'h2000, w_11}, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h0100, 16'h4000, w_beef, w_a5, 1,
                {1'b0, 1'b1, 16'h4000, w_beef}, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h3FF0, w_cafe, w_11, 2,
                {1'b0, 1'b1, 16'h3FF0, w_cafe}, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0080, 16'h0040, w_77, w_cafe, 1,
                {1'b1, 1'b0, 16'h0040, w_77}, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, '0, {LW{1'b1}}, 4,
                {1'b1, 1'b0, 16'hFFFF, 128'h0}, 1'b0};

    // Reset, including a request that must be ignored while held in reset
    idle_all();
    #3;
    chk("reset_out", 256'({pm, bus.i_resp, bus.d_resp, bus.arb_busy}), 256'(0));
    @(negedge clk); bus.i_read = 1'b1; bus.i_address = 16'h0042;
    @(posedge clk); #1;
    chk("reset_hold", 256'({pm, bus.arb_busy}), 256'(0));
    @(negedge clk); idle_all(); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_release", 256'({pm, bus.i_resp, bus.d_resp, bus.arb_busy}), 256'(0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a write-back
    @(negedge clk);
    bus.d_write = 1'b1; bus.d_address = 16'h4000; bus.d_wdata = w_beef;
    @(posedge clk); #1;
    chk("rst_pre", 256'({bus.pmem_write, bus.arb_busy}), 256'(2'b11));
    #1 rst_n = 1'b0;
    #1 chk("rst_async", 256'({pm, bus.arb_busy}), 256'(0));
    @(negedge clk); bus.pmem_resp = 1'b1; #1;
    chk("rst_no_resp", 256'({bus.d_resp, bus.i_resp}), 256'(0));
    @(negedge clk); idle_all(); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst_after", 256'({pm, bus.d_resp, bus.arb_busy}), 256'(0));

    // pmem_resp while idle is ignored
    @(negedge clk); bus.pmem_resp = 1'b1; bus.pmem_rdata = w_a5; #1;
    chk("idle_resp", 256'({bus.i_resp, bus.d_resp, bus.arb_busy}), 256'(0));
    @(posedge clk); #1;
    chk("idle_resp_state", 256'({bus.arb_busy, bus.pmem_read, bus.pmem_write}), 256'(0));
    @(negedge clk); idle_all();

    // Dcache first, then icache after the idle gap
    @(negedge clk);
    bus.d_write = 1'b1; bus.d_address = 16'h4000; bus.d_wdata = w_beef;
    bus.i_read = 1'b1; bus.i_address = 16'h0100;
    @(posedge clk); #1;
    chk("order_d_first", 256'(pm), 256'({1'b0, 1'b1, 16'h4000, w_beef}));
    @(negedge clk); bus.pmem_resp = 1'b1; #1;
    chk("order_d_resp", 256'({bus.i_resp, bus.d_resp}), 256'(2'b01));
    @(negedge clk); bus.pmem_resp = 1'b0; bus.d_write = 1'b0;
    gap = 0; found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.arb_busy) begin found = 1'b1; break; end
      gap++;
    end
    chk("order_i_next", 256'({found, pm}), 256'({1'b1, 1'b1, 1'b0, 16'h0100, 128'h0}));
    chk("order_gap", 256'(gap >= 1 && gap <= 2), 256'(1));
    @(negedge clk); bus.pmem_resp = 1'b1; bus.pmem_rdata = w_cafe; #1;
    chk("order_i_resp", 256'({bus.i_resp, bus.d_resp, bus.i_rdata}), 256'({2'b10, w_cafe}));
    @(negedge clk); idle_all();
    repeat (2) @(posedge clk);

    // Starvation bound: dcache always requesting, icache waiting
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_address = 16'h0500;
    bus.d_write = 1'b1; bus.d_address = 16'h6000; bus.d_wdata = w_11;
    n = 0; was_busy = 1'b0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(posedge clk); #1;
      if (bus.arb_busy && !was_busy) begin got[n] = int'(bus.pmem_write); n++; end
      was_busy = bus.arb_busy;
      @(negedge clk); bus.pmem_resp = bus.arb_busy;
    end
    chk("starve_budget", 256'(n), 256'(6));
    chk("starve_pattern", 256'({got[0][0], got[1][0], got[2][0], got[3][0], got[4][0], got[5][0]}),
        256'(6'b111101));
    @(negedge clk); idle_all();
    repeat (3) @(posedge clk);

    // Requester holds i_read through the dead cycle: no second fill
    @(negedge clk); bus.i_read = 1'b1; bus.i_address = 16'h0ABC;
    @(posedge clk); #1;
    chk("stale_grant", 256'(pm), 256'({1'b1, 1'b0, 16'h0ABC, 128'h0}));
    @(negedge clk); bus.pmem_resp = 1'b1; bus.pmem_rdata = w_77; #1;
    chk("stale_resp", 256'({bus.i_resp, bus.d_resp, bus.i_rdata}), 256'({2'b10, w_77}));
    @(negedge clk); bus.pmem_resp = 1'b0;
    @(posedge clk); #1 bus.i_read = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.pmem_read || bus.arb_busy) found = 1'b1;
    end
    chk("stale_no_regrant", 256'(found), 256'(0));
    @(negedge clk); idle_all();
    repeat (3) @(posedge clk);

    // Random traffic against a cycle-level model of the arbitration rules
    m_owner = 0; m_cool = 0; m_cnt = 0; m_lat = 0; m_exp = '0;
    i_pend = 1'b0; d_pend = 1'b0; i_hold = 0; d_hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      s_ir = bus.i_read; s_ia = bus.i_address;
      s_dr = bus.d_read; s_dw = bus.d_write; s_da = bus.d_address; s_wd = bus.d_wdata;
      s_resp = bus.pmem_resp;
      done = 0;
      if (m_owner != 0) begin
        if (s_resp) begin done = m_owner; m_owner = 0; m_cool = 1; end
      end else if (m_cool != 0) begin
        m_cool = 0;
        if (!s_ir) m_cnt = 0;
      end else if ((s_dr || s_dw) && (!s_ir || m_cnt < LIMIT)) begin
        m_owner = 2;
        m_exp = {s_dr & ~s_dw, s_dw, s_da, s_wd};
        m_cnt = s_ir ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
        m_lat = $urandom_range(0, 3);
      end else if (s_ir) begin
        m_owner = 1;
        m_exp = {1'b1, 1'b0, s_ia, 128'h0};
        m_cnt = 0;
        m_lat = $urandom_range(0, 3);
      end else begin
        m_cnt = 0;
      end
      if (m_owner == 0) m_exp = '0;
      if (done == 1) begin i_pend = 1'b0; i_hold = $urandom_range(0, 1); end
      if (done == 2) begin d_pend = 1'b0; d_hold = $urandom_range(0, 1); end
      #1;
      chk("rnd_pmem", 256'({pm, bus.arb_busy}), 256'({m_exp, m_owner != 0}));

      @(negedge clk);
      bus.pmem_rdata = {4{$urandom}};
      if (m_owner != 0) begin
        if (m_lat == 0) bus.pmem_resp = 1'b1;
        else begin bus.pmem_resp = 1'b0; m_lat--; end
      end else begin
        bus.pmem_resp = ($urandom_range(0, 9) == 0);
      end
      if (!i_pend) begin
        if (i_hold > 0) i_hold--;
        else begin
          bus.i_read = 1'b0;
          if ($urandom_range(0, 2) == 0) begin
            i_pend = 1'b1; bus.i_read = 1'b1; bus.i_address = AW'($urandom);
          end
        end
      end else if (m_owner == 1) begin
        if ($urandom_range(0, 1) == 0) bus.i_address = AW'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        i_pend = 1'b0; bus.i_read = 1'b0;
      end
      if (!d_pend) begin
        if (d_hold > 0) d_hold--;
        else begin
          bus.d_read = 1'b0; bus.d_write = 1'b0;
          if ($urandom_range(0, 2) == 0) begin
            op = 2'($urandom_range(1, 3));
            d_pend = 1'b1; bus.d_read = op[0]; bus.d_write = op[1];
            bus.d_address = AW'($urandom); bus.d_wdata = {4{$urandom}};
          end
        end
      end else if (m_owner == 2) begin
        if ($urandom_range(0, 1) == 0) begin
          bus.d_address = AW'($urandom); bus.d_wdata = {4{$urandom}};
        end
      end else if ($urandom_range(0, 19) == 0) begin
        d_pend = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      end
      #1;
      chk("rnd_resp", 256'({bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata}),
          256'({(m_owner == 1) && bus.pmem_resp, (m_owner == 2) && bus.pmem_resp,
                bus.pmem_rdata, bus.pmem_rdata}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs).
- Sits between the two L1 caches and pmem. The fetch stage and the mem stage stall on their own cache's resp until this block services the miss.
- Dcache has priority, because it serves the older instruction in the mem stage. A starvation counter bounds how long icache can wait.

Parameters:
- ADDR_W, 16, address width of all address ports.
- LINE_W, 128, cache line width in bits.
- STARVE_LIMIT, 4, maximum consecutive dcache grants allowed while icache is waiting; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  icache line-fill request; held high until i_resp.
- i_address  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  fill data to icache.
- i_resp  out  1  icache transaction done.
- d_read  in  1  dcache line-fill request; held until d_resp.
- d_write  in  1  dcache write-back request; held until d_resp.
- d_address  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  write-back data.
- d_rdata  out  LINE_W  fill data to dcache.
- d_resp  out  1  dcache transaction done.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_W  physical memory address.
- pmem_wdata  out  LINE_W  physical memory write data.
- pmem_rdata  in  LINE_W  physical memory read data.
- pmem_resp  in  1  physical memory done; single-cycle pulse.
- arb_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous on rst_n low and clears the following immediately, with no clock edge needed:
  - state = IDLE;
  - pmem_read = 0, pmem_write = 0;
  - pmem_address = 0, pmem_wdata = 0;
  - starve_cnt = 0;
  - i_resp = 0, d_resp = 0;
  - arb_busy = 0.
- Reset mid-transaction abandons the transaction. No resp is issued, and pmem is required to abort on the strobe drop.
- FSM states are IDLE, SERVE_I, SERVE_D.
- In IDLE the arbiter evaluates requests every cycle:
  - d_req = d_read | d_write.
  - If d_req and (!i_read or starve_cnt < STARVE_LIMIT): go to SERVE_D and latch d_address, d_wdata and the op.
  - If d_read and d_write are both high, the op is write.
  - Else if i_read: go to SERVE_I and latch i_address.
  - Else: stay in IDLE.
- Grant latency: a request sampled in IDLE at edge N gives pmem strobe high in cycle N+1.
- pmem_read, pmem_write, pmem_address and pmem_wdata are registered from the latched values. They are constant for the whole serve state and low/zero in IDLE.
- SERVE_I:
  - pmem_read = 1.
  - i_resp = pmem_resp, combinational.
  - On pmem_resp, go to IDLE.
- SERVE_D:
  - pmem_read = latched read, pmem_write = latched write.
  - d_resp = pmem_resp, combinational.
  - On pmem_resp, go to IDLE.
- Every serve state returns to IDLE for at least one cycle. This dead cycle lets the requester drop its request, so a stale request is never re-granted.
- Back-to-back transactions cost at least 1 idle cycle between them.
- i_rdata and d_rdata are continuous passthroughs of pmem_rdata. They are valid only when the matching resp is high.
- resp is never asserted to the non-owner.
- pmem_resp while in IDLE is ignored.
- starve_cnt (4-bit) is updated at the IDLE grant decision:
  - Dcache granted while i_read is high: starve_cnt + 1, saturating at STARVE_LIMIT.
  - Icache granted: cleared to 0.
  - i_read low in IDLE: cleared to 0.
- At starve_cnt == STARVE_LIMIT with both requesting, icache wins exactly once, then the counter clears.
- A request deasserted before grant is legal and is simply not served.
- Requesters must keep address and data stable until resp. The arbiter latches them anyway, so changes after grant have no effect.
- No combinational path exists from the i_*/d_* request inputs to the pmem_* outputs.

Test Plan:
- Reset with no requests: all outputs 0 and state IDLE; assert rst_n during SERVE_D with pmem_write = 1 -> pmem_write drops to 0 without a clock edge, and no d_resp follows.
- i_read alone at address 0x1230, pmem_resp 3 cycles after the strobe, pmem_rdata = 0xA5..A5 -> pmem_read high 3 cycles, pmem_address = 0x1230, i_resp one pulse carrying that data, d_resp stays 0.
- d_write at 0x4000 with d_wdata = 0xDEAD_BEEF_... while i_read is high at 0x0100 -> dcache is served first (pmem_write = 1); after 1 IDLE cycle, icache is served at 0x0100.
- Dcache re-requests continuously with i_read held high and STARVE_LIMIT = 4 -> exactly 4 dcache grants, then one icache grant, then starve_cnt = 0.
- d_read and d_write both high -> pmem_write = 1 and pmem_read = 0; a pmem_resp pulse injected in IDLE -> no i_resp or d_resp.
- After i_resp, requester keeps i_read high for exactly 1 extra cycle (the dead cycle) then drops it -> no second pmem_read is issued.
